gray_histogram: RTL and testbench



---
 rtl/gray_histogram_if.sv | 29 ++
 rtl/gray_histogram.sv | 157 +++++++++++++++
 tb/tb_gray_histogram.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_histogram_if.sv
// Pixel-in / histogram-out bundle for gray_histogram.
// The slave modport is the histogram block's view.
interface gray_histogram_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 20
);
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             frame_end;
    logic             ready;
    logic [PIX_W-1:0] hist_bin;
    logic [CNT_W-1:0] hist_count;
    logic             hist_valid;
    logic             hist_ready;
    logic             hist_last;
    logic             drop_err;

    modport slave (
        input  pix_in, pix_valid, frame_end, hist_ready,
        output ready, hist_bin, hist_count, hist_valid,
        output hist_last, drop_err
    );

    modport master (
        output pix_in, pix_valid, frame_end, hist_ready,
        input  ready, hist_bin, hist_count, hist_valid,
        input  hist_last, drop_err
    );
endinterface

// File: rtl/gray_histogram.sv
// Per-frame pixel histogram: clear, accumulate, drain, dump-and-clear.
// Define GRAY_HIST_SAT_EN for saturating bins; default wraps.
module gray_histogram #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    gray_histogram_if.slave   bus
);
    localparam int NBINS = 1 << PIX_W;

    typedef enum logic [2:0] {
        S_CLEAR, S_ACCUM, S_DRAIN0, S_DRAIN1, S_DUMP
    } state_e;

    state_e           state_q, state_d;
    logic [PIX_W:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0] mem [NBINS];
    logic [CNT_W-1:0] rd_q;

    logic             s1_vld_q;
    logic [PIX_W-1:0] s1_addr_q;
    logic             s2_vld_q;
    logic [PIX_W-1:0] s2_addr_q;
    logic [CNT_W-1:0] s2_val_q;

    logic             pend_q;
    logic [PIX_W-1:0] pend_bin_q;
    logic             sv_q;
    logic [PIX_W-1:0] sb_q;
    logic [CNT_W-1:0] sc_q;
    logic             drop_q;

    logic             accept, issue, fire, last_fire;
    logic             out_valid;
    logic [PIX_W-1:0] out_bin;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] cur, inc;
    logic             we, rd_en;
    logic [PIX_W-1:0] waddr, raddr;
    logic [CNT_W-1:0] wdata;

    // Output beat comes from the skid when it is full, else the RAM read.
    assign out_valid = sv_q | pend_q;
    assign out_bin   = sv_q ? sb_q : pend_bin_q;
    assign out_cnt   = sv_q ? sc_q : rd_q;
    assign fire      = out_valid & bus.hist_ready;
    assign last_fire = fire && (out_bin == '1);

    assign accept = (state_q == S_ACCUM) & bus.pix_valid;
    assign issue  = (state_q == S_DUMP) & ~ptr_q[PIX_W] & ~sv_q;

    assign cur = (s2_vld_q && s2_addr_q == s1_addr_q) ? s2_val_q : rd_q;
`ifdef GRAY_HIST_SAT_EN
    assign inc = (&cur) ? cur : cur + CNT_W'(1);
`else
    assign inc = cur + CNT_W'(1);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q[PIX_W-1:0] == '1) begin
                    state_d = S_ACCUM;
                    ptr_d   = '0;
                end
            end
            S_ACCUM:  if (bus.frame_end) state_d = S_DRAIN0;
            S_DRAIN0: state_d = S_DRAIN1;
            S_DRAIN1: state_d = S_DUMP;
            S_DUMP: begin
                if (issue) ptr_d = ptr_q + 1'b1;
                if (last_fire) begin
                    state_d = S_ACCUM;
                    ptr_d   = '0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        we    = s1_vld_q;
        waddr = s1_addr_q;
        wdata = inc;
        if (state_q == S_CLEAR) begin
            we    = 1'b1;
            waddr = ptr_q[PIX_W-1:0];
            wdata = '0;
        end else if (state_q == S_DUMP) begin
            we    = fire;
            waddr = out_bin;
            wdata = '0;
        end
        rd_en = accept | issue;
        raddr = issue ? ptr_q[PIX_W-1:0] : bus.pix_in;
    end

    // Read-before-write RAM; same-address hazards are covered by s2 forwarding.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (rd_en) rd_q <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            ptr_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_val_q   <= '0;
            pend_q     <= 1'b0;
            pend_bin_q <= '0;
            sv_q       <= 1'b0;
            sb_q       <= '0;
            sc_q       <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            s1_vld_q <= accept;
            if (accept) s1_addr_q <= bus.pix_in;
            s2_vld_q  <= s1_vld_q;
            s2_addr_q <= s1_addr_q;
            s2_val_q  <= inc;
            if (issue) begin
                pend_q     <= 1'b1;
                pend_bin_q <= ptr_q[PIX_W-1:0];
            end else if (!sv_q && fire) begin
                pend_q <= 1'b0;
            end
            // Prefetch overwrites rd_q, so a stalled beat parks in the skid.
            if (sv_q) begin
                if (fire) sv_q <= 1'b0;
            end else if (issue && pend_q && !fire) begin
                sv_q <= 1'b1;
                sb_q <= pend_bin_q;
                sc_q <= rd_q;
            end
            if ((bus.pix_valid || bus.frame_end) && state_q != S_ACCUM)
                drop_q <= 1'b1;
        end
    end

    assign bus.ready      = (state_q == S_ACCUM);
    assign bus.hist_valid = out_valid;
    assign bus.hist_bin   = out_valid ? out_bin : '0;
    assign bus.hist_count = out_valid ? out_cnt : '0;
    assign bus.hist_last  = out_valid && (out_bin == '1);
    assign bus.drop_err   = drop_q;
endmodule

// File: tb/tb_gray_histogram.sv
// Bench for gray_histogram: per-bin count model plus directed frames.
// A second instance with CNT_W=4 exercises counter overflow.
module tb_gray_histogram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_histogram_if #(.PIX_W(8), .CNT_W(20)) hif ();
    gray_histogram_if #(.PIX_W(8), .CNT_W(4))  hif2 ();

    gray_histogram #(.PIX_W(8), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .bus(hif)
    );
    gray_histogram #(.PIX_W(8), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .bus(hif2)
    );

    int passed = 0;
    int total  = 0;
    int mdl  [256];
    int snap [256];
    int got  [256];
    int fq   [$];
    int exp_bin = 0;
    int beats = 0;
    bit dump_done = 1'b0;
    bit prev_stall = 1'b0;

    task automatic chk(input string name, input longint act,
                       input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every beat is checked against the model; an accepted bin empties it.
    always @(negedge clk) begin
        if (rst) begin
            foreach (mdl[i]) mdl[i] = 0;
            exp_bin    = 0;
            beats      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("valid_hold", hif.hist_valid, 1);
            if (hif.hist_valid) begin
                chk("beat_bin", hif.hist_bin, exp_bin);
                chk("beat_count", hif.hist_count, mdl[exp_bin]);
                chk("beat_last", hif.hist_last, exp_bin == 255);
                chk("beat_ready_low", hif.ready, 0);
                if (hif.hist_ready) begin
                    got[exp_bin] = int'(hif.hist_count);
                    mdl[exp_bin] = 0;
                    beats++;
                    if (exp_bin == 255) begin
                        dump_done = 1'b1;
                        exp_bin = 0;
                    end else begin
                        exp_bin++;
                    end
                end
            end
            prev_stall = hif.hist_valid && !hif.hist_ready;
        end
    end

    task automatic do_reset(input int drop_at);
        int n;
        bit seen;
        rst = 1'b1;
        hif.pix_valid = 0;
        hif.frame_end = 0;
        hif.hist_ready = 0;
        repeat (3) cyc();
        chk("rst_ready", hif.ready, 0);
        chk("rst_valid", hif.hist_valid, 0);
        chk("rst_last", hif.hist_last, 0);
        chk("rst_bin", hif.hist_bin, 0);
        chk("rst_count", hif.hist_count, 0);
        chk("rst_drop", hif.drop_err, 0);
        rst = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 400) begin
            cyc();
            n++;
            if (hif.hist_valid) seen = 1'b1;
            if (hif.ready) break;
            hif.pix_valid = (n == drop_at);
            hif.pix_in = 8'd42;
        end
        hif.pix_valid = 0;
        chk("clear_len", n, 256);
        chk("no_beats_in_clear", seen, 0);
    endtask

    task automatic send_frame(input bit fe_last);
        int n;
        foreach (fq[i]) begin
            hif.pix_valid = 1'b1;
            hif.pix_in = 8'(fq[i]);
            mdl[fq[i]] = (mdl[fq[i]] + 1) % (1 << 20);
            hif.frame_end = fe_last && (i == fq.size() - 1);
            cyc();
        end
        hif.pix_valid = 1'b0;
        if (!fe_last || fq.size() == 0) begin
            hif.frame_end = 1'b1;
            cyc();
        end
        hif.frame_end = 1'b0;
        fq.delete();
        chk("ready_fall", hif.ready, 0);
        n = 0;
        while (!hif.hist_valid && n < 10) begin
            cyc();
            n++;
        end
        chk("first_valid_lat", n, 3);
    endtask

    task automatic run_dump(input bit rnd, input int stop_at);
        int n;
        int nbad;
        n = 0;
        nbad = 0;
        snap = mdl;
        beats = 0;
        dump_done = 1'b0;
        foreach (got[i]) got[i] = -1;
        while (!dump_done && n < 5000) begin
            hif.hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            n++;
            if (stop_at > 0 && beats >= stop_at) return;
        end
        hif.hist_ready = 1'b0;
        chk("dump_complete", beats, 256);
        chk("ready_after_last", hif.ready, 1);
        foreach (got[i]) if (got[i] != snap[i]) nbad++;
        chk("dump_vs_model", nbad, 0);
    endtask

    logic [23:0] rgb [3];
    int chx [3][3];

    initial begin
        int n, b, c3, other;
        hif.pix_in = '0;
        hif.pix_valid = 0;
        hif.frame_end = 0;
        hif.hist_ready = 0;
        hif2.pix_in = '0;
        hif2.pix_valid = 0;
        hif2.frame_end = 0;
        hif2.hist_ready = 0;
        foreach (mdl[i]) mdl[i] = 0;

        do_reset(0);

        // Empty frame: all 256 bins read back as zero.
        send_frame(1'b0);
        run_dump(1'b0, 0);
        n = 0;
        foreach (got[i]) if (got[i] != 0) n++;
        chk("empty_nonzero_bins", n, 0);

        // Three RGB pixels; each channel select gives its own histogram.
        rgb[0] = {8'd255, 8'd17, 8'd3};
        rgb[1] = {8'd128, 8'd17, 8'd200};
        rgb[2] = {8'd64,  8'd90, 8'd3};
        chx[0] = '{255, 128, 64};
        chx[1] = '{17, 2, 90};
        chx[2] = '{3, 2, 200};
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 3; p++)
                fq.push_back(int'((rgb[p] >> (16 - 8 * c)) & 24'hFF));
            send_frame(1'b0);
            if (c == 0) chk("model_pin_ch0", mdl[255] + mdl[128] + mdl[64], 3);
            run_dump(1'b0, 0);
            if (c == 0) begin
                chk("ch0_b255", got[255], 1);
                chk("ch0_b128", got[128], 1);
                chk("ch0_b64", got[64], 1);
            end else begin
                chk("chn_pair", got[chx[c][0]], chx[c][1]);
                chk("chn_single", got[chx[c][2]], 1);
            end
        end

        // 1000 identical pixels, frame_end on the last one.
        repeat (1000) fq.push_back(7);
        send_frame(1'b1);
        chk("model_pin_b7", mdl[7], 1000);
        run_dump(1'b0, 0);
        chk("b7_count", got[7], 1000);

        // Mixed hazards, stalled dump, then a fresh frame from zero.
        fq = '{5, 5, 9, 5, 9, 9, 5};
        send_frame(1'b1);
        run_dump(1'b1, 0);
        chk("b5_count", got[5], 4);
        chk("b9_count", got[9], 3);
        fq.push_back(1);
        send_frame(1'b0);
        run_dump(1'b1, 0);
        chk("fresh_b5", got[5], 0);
        chk("fresh_b1", got[1], 1);
        chk("drop_clean", hif.drop_err, 0);

        // Reset in the middle of a dump, with a pixel dropped during CLEAR.
        fq = '{1, 2, 3};
        send_frame(1'b0);
        run_dump(1'b0, 100);
        do_reset(5);
        chk("drop_set", hif.drop_err, 1);
        fq = '{9, 9};
        send_frame(1'b0);
        run_dump(1'b0, 0);
        chk("after_rst_b9", got[9], 2);
        chk("after_rst_b42", got[42], 0);

        // Narrow counters: 20 hits on a 4-bit bin.
        n = 0;
        while (!hif2.ready && n < 400) begin
            cyc();
            n++;
        end
        chk("dut2_ready", hif2.ready, 1);
        for (int i = 0; i < 20; i++) begin
            hif2.pix_valid = 1'b1;
            hif2.pix_in = 8'd3;
            hif2.frame_end = (i == 19);
            cyc();
        end
        hif2.pix_valid = 1'b0;
        hif2.frame_end = 1'b0;
        hif2.hist_ready = 1'b1;
        b = 0;
        c3 = -1;
        other = 0;
        n = 0;
        while (n < 400 && b < 256) begin
            cyc();
            n++;
            if (hif2.hist_valid) begin
                if (hif2.hist_bin == 8'd3) c3 = int'(hif2.hist_count);
                else other += int'(hif2.hist_count);
                b++;
            end
        end
        chk("dut2_beats", b, 256);
`ifdef GRAY_HIST_SAT_EN
        chk("dut2_b3_sat", c3, 15);
`else
        chk("dut2_b3_wrap", c3, 4);
`endif
        chk("dut2_others", other, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
